// File: rtl/pwm_reg_pkg.sv
// Shared types and constants for the PWM register-file access path.
package pwm_reg_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    // Register address map of the PWM register file.
    localparam logic [ADDR_W-1:0] REG_CTRL      = 6'h00;
    localparam logic [ADDR_W-1:0] REG_STATUS    = 6'h01;
    localparam logic [ADDR_W-1:0] REG_PERIOD_LO = 6'h02;
    localparam logic [ADDR_W-1:0] REG_PERIOD_HI = 6'h03;
    localparam logic [ADDR_W-1:0] REG_DUTY_LO   = 6'h04;
    localparam logic [ADDR_W-1:0] REG_DUTY_HI   = 6'h05;

    // One register access: write when we = 1, read otherwise.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } reg_req_t;

    // Which requester the access currently on the bus belongs to.
    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

endpackage

// File: rtl/reg_arb_skid.sv
// One-entry pending slot for the non-stallable A requester.
// A push while the slot is full and not popping on the same edge is lost
// and sets the sticky overflow flag.
module reg_arb_skid
    import pwm_reg_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  reg_req_t push_req,
    input  logic     pop,
    output logic     valid,
    output reg_req_t entry,
    output logic     ovf
);

    // Slot occupancy, stored entry and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            entry <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push && (!valid || pop)) begin
                valid <= 1'b1;
                entry <= push_req;
            end else if (pop) begin
                valid <= 1'b0;
            end
            if (push && valid && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arb.sv
// Register-bus arbiter between the SPI decoder (A, pulses, cannot stall)
// and the update sequencer (B, req/gnt). One access per cycle, registered
// bus outputs, read data routed back to the port that issued the read.
module reg_bus_arb
    import pwm_reg_pkg::*;
#(
    parameter int MAX_A_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    output logic              a_ovf,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              reg_read,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    localparam int                CNT_W   = $clog2(MAX_A_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_A_BURST);

    reg_req_t         a_cap;
    reg_req_t         slot_req;
    reg_req_t         win_req;
    logic             slot_valid;
    logic             b_pend;
    logic             a_win;
    logic             b_win;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    owner_e           owner;

    // Capture of an A pulse; a coinciding read and write is taken as a write.
    always_comb begin
        a_cap.we    = a_write;
        a_cap.addr  = a_addr;
        a_cap.wdata = a_wdata;
    end

    reg_arb_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (a_read | a_write),
        .push_req (a_cap),
        .pop      (a_win),
        .valid    (slot_valid),
        .entry    (slot_req),
        .ovf      (a_ovf)
    );

    // Handshake on B: b_req is held with stable fields until b_gnt; the
    // access is transferred on the edge that raises b_gnt, so during the
    // b_gnt cycle b_req still shows the served request and is masked.
    // Dropping b_req before b_gnt withdraws the request.
    // Arbitration: A wins ties unless B has waited MAX_A_BURST A grants.
    always_comb begin
        b_pend     = b_req && !b_gnt;
        a_win      = slot_valid && !(b_pend && (starve_cnt == CNT_MAX));
        b_win      = b_pend && !a_win;
        starve_nxt = starve_cnt;
        if (b_win || !b_pend) begin
            starve_nxt = '0;
        end else if (a_win && (starve_cnt != CNT_MAX)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
        win_req = slot_req;
        if (!a_win) begin
            win_req.we    = b_we;
            win_req.addr  = b_addr;
            win_req.wdata = b_wdata;
        end
    end

    // Issue registers: the winner of cycle M drives the bus during M+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_read   <= 1'b0;
            reg_write  <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            b_gnt      <= 1'b0;
            owner      <= OWNER_A;
            starve_cnt <= '0;
        end else begin
            reg_read   <= (a_win || b_win) && !win_req.we;
            reg_write  <= (a_win || b_win) && win_req.we;
            reg_addr   <= (a_win || b_win) ? win_req.addr : '0;
            reg_wdata  <= (a_win || b_win) ? win_req.wdata : '0;
            b_gnt      <= b_win;
            starve_cnt <= starve_nxt;
            if (a_win) begin
                owner <= OWNER_A;
            end else if (b_win) begin
                owner <= OWNER_B;
            end
        end
    end

    // Read return: sample reg_rdata at the end of the issue cycle for the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= reg_read && (owner == OWNER_A);
            b_rvalid <= reg_read && (owner == OWNER_B);
            if (reg_read && (owner == OWNER_A)) begin
                a_rdata <= reg_rdata;
            end
            if (reg_read && (owner == OWNER_B)) begin
                b_rdata <= reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_arb.sv
// Self-checking bench for reg_bus_arb: scenario tasks with inline checks plus
// a bus/read-return scoreboard fed by expected queues.
module tb_reg_bus_arb;

    logic       clk;
    logic       rst;
    logic       a_read;
    logic       a_write;
    logic [5:0] a_addr;
    logic [7:0] a_wdata;
    logic [7:0] a_rdata;
    logic       a_rvalid;
    logic       a_ovf;
    logic       b_req;
    logic       b_we;
    logic [5:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_gnt;
    logic [7:0] b_rdata;
    logic       b_rvalid;
    logic       reg_read;
    logic       reg_write;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    int checks = 0;
    int errors = 0;

    // {we, addr, wdata} of every access expected on the register bus, in order
    logic [14:0] exp_q[$];
    logic [7:0]  a_rd_q[$];
    logic [7:0]  b_rd_q[$];

    reg_bus_arb #(.MAX_A_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_read    (a_read),
        .a_write   (a_write),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .a_ovf     (a_ovf),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .reg_read  (reg_read),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register file read model: fixed contents per address
    function automatic logic [7:0] rom_val(input logic [5:0] addr);
        case (addr)
            6'h02:   rom_val = 8'h3C;
            6'h07:   rom_val = 8'h71;
            6'h09:   rom_val = 8'h92;
            default: rom_val = {2'b00, addr} ^ 8'h5A;
        endcase
    endfunction

    assign reg_rdata = rom_val(reg_addr);

    // Scoreboard: compare every bus access and every rvalid against the queues
    always @(negedge clk) begin
        logic [14:0] e;
        logic [7:0]  d;
        if (reg_read || reg_write) begin
            checks++;
            if (reg_read && reg_write) begin
                errors++;
                $display("FAIL bus_both_strobes: read=%b write=%b, required one-hot", reg_read, reg_write);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: we=%b addr=%h wdata=%h, required no access", reg_write, reg_addr, reg_wdata);
            end else begin
                e = exp_q.pop_front();
                if (e[14] !== reg_write || e[13:8] !== reg_addr || (e[14] && e[7:0] !== reg_wdata)) begin
                    errors++;
                    $display("FAIL bus_access: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             reg_write, reg_addr, reg_wdata, e[14], e[13:8], e[7:0]);
                end
            end
        end
        if (a_rvalid) begin
            checks++;
            if (a_rd_q.size() == 0) begin
                errors++;
                $display("FAIL a_rvalid_unexpected: a_rdata=%h, required no a_rvalid", a_rdata);
            end else begin
                d = a_rd_q.pop_front();
                if (a_rdata !== d) begin
                    errors++;
                    $display("FAIL a_rdata: got %h required %h", a_rdata, d);
                end
            end
        end
        if (b_rvalid) begin
            checks++;
            if (b_rd_q.size() == 0) begin
                errors++;
                $display("FAIL b_rvalid_unexpected: b_rdata=%h, required no b_rvalid", b_rdata);
            end else begin
                d = b_rd_q.pop_front();
                if (b_rdata !== d) begin
                    errors++;
                    $display("FAIL b_rdata: got %h required %h", b_rdata, d);
                end
            end
        end
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
        a_read  = 1'b0;
        a_write = 1'b0;
    endtask

    task automatic a_pulse(input logic we, input logic [5:0] addr, input logic [7:0] data);
        a_write = we;
        a_read  = !we;
        a_addr  = addr;
        a_wdata = data;
    endtask

    task automatic b_drive(input logic req, input logic we, input logic [5:0] addr, input logic [7:0] data);
        b_req   = req;
        b_we    = we;
        b_addr  = addr;
        b_wdata = data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        checks++;
        if ({a_rvalid, a_ovf, b_gnt, b_rvalid, reg_read, reg_write} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 000000",
                     {a_rvalid, a_ovf, b_gnt, b_rvalid, reg_read, reg_write});
        end
        checks++;
        if ({a_rdata, b_rdata, reg_addr, reg_wdata} !== 30'b0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h addr=%h wdata=%h required all 0",
                     a_rdata, b_rdata, reg_addr, reg_wdata);
        end
        next_cycle();
        rst = 1'b0;
        idle(2);
    endtask

    // A write pulse at cycle n appears on the bus at n+2, no read return
    task automatic test_a_write();
        next_cycle();
        a_pulse(1'b1, 6'h05, 8'hA5);
        exp_q.push_back({1'b1, 6'h05, 8'hA5});
        next_cycle();
        @(negedge clk);
        checks++;
        if (reg_write !== 1'b0) begin
            errors++;
            $display("FAIL a_write_early: reg_write=%b at n+1, required 0", reg_write);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({reg_write, reg_read, reg_addr, reg_wdata} !== {1'b1, 1'b0, 6'h05, 8'hA5}) begin
            errors++;
            $display("FAIL a_write_bus: got w=%b r=%b addr=%h data=%h required w=1 r=0 addr=05 data=a5",
                     reg_write, reg_read, reg_addr, reg_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL a_write_rvalid: a_rvalid=%b required 0", a_rvalid);
        end
        idle(2);
    endtask

    // B read with idle bus: gnt and bus next cycle, data one cycle later
    task automatic test_b_read();
        next_cycle();
        b_drive(1'b1, 1'b0, 6'h02, 8'h00);
        exp_q.push_back({1'b0, 6'h02, 8'h00});
        b_rd_q.push_back(8'h3C);
        next_cycle();
        @(negedge clk);
        checks++;
        if ({b_gnt, reg_read, reg_addr} !== {1'b1, 1'b1, 6'h02}) begin
            errors++;
            $display("FAIL b_read_issue: got gnt=%b read=%b addr=%h required gnt=1 read=1 addr=02",
                     b_gnt, reg_read, reg_addr);
        end
        next_cycle();
        b_drive(1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        checks++;
        if ({b_rvalid, b_rdata, b_gnt} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL b_read_return: got rvalid=%b rdata=%h gnt=%b required 1 3c 0",
                     b_rvalid, b_rdata, b_gnt);
        end
        idle(2);
    endtask

    // A pulses every cycle with B waiting: 4 A grants, then B, then A resumes.
    // When drop_third is set, A also pulses in the B-grant decision cycle and
    // that pulse is lost to a full slot.
    task automatic starve_run(input logic drop_third, input string tag);
        logic [7:0] wd[6];
        for (int i = 0; i < 6; i++) wd[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 6'(6'h10 + i), wd[i]});
        exp_q.push_back({1'b1, 6'h20, 8'hB0});
        exp_q.push_back({1'b1, 6'h14, wd[4]});
        if (!drop_third) exp_q.push_back({1'b1, 6'h15, wd[5]});
        next_cycle();
        a_pulse(1'b1, 6'h10, wd[0]);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) b_drive(1'b1, 1'b1, 6'h20, 8'hB0);
            if (k <= 4) a_pulse(1'b1, 6'(6'h10 + k), wd[k]);
            if (k == 5 && drop_third) a_pulse(1'b1, 6'h15, wd[5]);
            if (k == 6 && !drop_third) a_pulse(1'b1, 6'h15, wd[5]);
            @(negedge clk);
            checks++;
            if (b_gnt !== (k == 6)) begin
                errors++;
                $display("FAIL %s_gnt_cycle%0d: b_gnt=%b required %b", tag, k, b_gnt, (k == 6));
            end
        end
        next_cycle();
        b_drive(1'b0, 1'b0, 6'h00, 8'h00);
        idle(4);
        @(negedge clk);
        checks++;
        if (a_ovf !== drop_third) begin
            errors++;
            $display("FAIL %s_ovf: a_ovf=%b required %b", tag, a_ovf, drop_third);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d accesses outstanding, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_starvation();
        starve_run(1'b0, "starve");
    endtask

    task automatic test_overflow();
        starve_run(1'b1, "ovf");
        idle(3);
        @(negedge clk);
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: a_ovf=%b required 1", a_ovf);
        end
    endtask

    // A read and B read pending together: A first, B next, returns separated
    task automatic test_back_to_back();
        exp_q.push_back({1'b0, 6'h07, 8'h00});
        exp_q.push_back({1'b0, 6'h09, 8'h00});
        a_rd_q.push_back(8'h71);
        b_rd_q.push_back(8'h92);
        next_cycle();
        a_pulse(1'b0, 6'h07, 8'h00);
        next_cycle();
        b_drive(1'b1, 1'b0, 6'h09, 8'h00);
        next_cycle();
        @(negedge clk);
        checks++;
        if ({reg_read, reg_addr, b_gnt} !== {1'b1, 6'h07, 1'b0}) begin
            errors++;
            $display("FAIL b2b_a_first: got read=%b addr=%h gnt=%b required 1 07 0", reg_read, reg_addr, b_gnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({b_gnt, reg_addr, a_rvalid, a_rdata, b_rvalid} !== {1'b1, 6'h09, 1'b1, 8'h71, 1'b0}) begin
            errors++;
            $display("FAIL b2b_b_second: got gnt=%b addr=%h a_rv=%b a_rd=%h b_rv=%b required 1 09 1 71 0",
                     b_gnt, reg_addr, a_rvalid, a_rdata, b_rvalid);
        end
        next_cycle();
        b_drive(1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        checks++;
        if ({b_rvalid, b_rdata, a_rvalid} !== {1'b1, 8'h92, 1'b0}) begin
            errors++;
            $display("FAIL b2b_b_return: got b_rv=%b b_rd=%h a_rv=%b required 1 92 0", b_rvalid, b_rdata, a_rvalid);
        end
        idle(2);
        @(negedge clk);
        checks++;
        if (a_rdata !== 8'h71) begin
            errors++;
            $display("FAIL a_rdata_hold: got %h required 71", a_rdata);
        end
    endtask

    // Reset during the issue cycle of an A read with another A entry pending
    task automatic test_reset_mid();
        exp_q.push_back({1'b0, 6'h07, 8'h00});
        next_cycle();
        a_pulse(1'b0, 6'h07, 8'h00);
        next_cycle();
        a_pulse(1'b1, 6'h30, 8'h33);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({reg_read, reg_addr} !== {1'b1, 6'h07}) begin
            errors++;
            $display("FAIL rstmid_issue: got read=%b addr=%h required 1 07", reg_read, reg_addr);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_rvalid, a_ovf, b_gnt, b_rvalid, reg_read, reg_write, a_rdata, b_rdata, reg_addr, reg_wdata}
            !== 36'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: rv=%b ovf=%b gnt=%b brv=%b r=%b w=%b ard=%h brd=%h addr=%h wd=%h required all 0",
                     a_rvalid, a_ovf, b_gnt, b_rvalid, reg_read, reg_write, a_rdata, b_rdata, reg_addr, reg_wdata);
        end
        idle(5);
    endtask

    initial begin
        rst = 1'b1;
        a_read = 1'b0;
        a_write = 1'b0;
        a_addr = '0;
        a_wdata = '0;
        b_drive(1'b0, 1'b0, 6'h00, 8'h00);
        test_reset();
        test_a_write();
        test_b_read();
        test_starvation();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || a_rd_q.size() != 0 || b_rd_q.size() != 0) begin
            errors++;
            $display("FAIL final_queues: bus=%0d a=%0d b=%0d outstanding, required 0",
                     exp_q.size(), a_rd_q.size(), b_rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
